serial_add_sequencer: RTL

Multi-cycle controller that sequences a single one-bit full-adder cell to perform WIDTH-bit add or subtract, one bit per clock, LSB first. It is the low-area arithmetic path for the 8-bit CPU's ALU.
- The decode stage issues a start pulse with operands and an op select.
- The block returns result, carry-out, overflow and zero flags with a one-cycle done pulse.
- A start/busy handshake serialises requests.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/serial_add_sequencer_fa.sv | 13 +
 rtl/serial_add_sequencer.sv | 131 +++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: ALU op encoding, sequencer FSM states, default datapath width.
package cpu_pkg;

  localparam int   CPU_W  = 8;
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_e;

endpackage

// File: rtl/serial_add_sequencer_fa.sv
// One-bit full adder cell; the only arithmetic element in the serial ALU path.
module serial_add_sequencer_fa (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  assign sum  = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/serial_add_sequencer.sv
// Bit-serial WIDTH-bit add/subtract: one full-adder step per clock, LSB first,
// with carry/overflow/zero flags and a one-cycle done pulse.
module serial_add_sequencer
  import cpu_pkg::*;
#(
  parameter int WIDTH = CPU_W,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op_sub,
  input  logic [WIDTH-1:0] a_in,
  input  logic [WIDTH-1:0] b_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result,
  output logic             cout,
  output logic             ovf,
  output logic             zero
);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sr_q, sr_d;
  logic               carry_q, carry_d;
  logic [CNT_W-1:0]   idx_q, idx_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic               cout_q, cout_d;
  logic               ovf_q, ovf_d;
  logic               zero_q, zero_d;

  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;
  logic               c_msb;
  logic [WIDTH-1:0]   sr_next;

  serial_add_sequencer_fa u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  assign last_bit = (idx_q == CNT_W'(WIDTH - 1));
  assign sr_next  = {fa_sum, sr_q[WIDTH-1:1]};
  // On the MSB step the carry FF holds the carry into the sign bit.
  assign c_msb    = carry_q;

  always_comb begin
    state_d  = state_q;
    sa_d     = sa_q;
    sb_d     = sb_q;
    sr_d     = sr_q;
    carry_d  = carry_q;
    idx_d    = idx_q;
    result_d = result_q;
    cout_d   = cout_q;
    ovf_d    = ovf_q;
    zero_d   = zero_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          // Subtract folds into the adder as A + ~B with carry-in 1.
          state_d = S_RUN;
          sa_d    = a_in;
          sb_d    = op_sub ? ~b_in : b_in;
          carry_d = op_sub;
          sr_d    = '0;
          idx_d   = '0;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        sr_d    = sr_next;
        carry_d = fa_cout;
        idx_d   = idx_q + CNT_W'(1);
        if (last_bit) begin
          state_d  = S_DONE;
          idx_d    = '0;
          result_d = sr_next;
          cout_d   = fa_cout;
          ovf_d    = c_msb ^ fa_cout;
          zero_d   = (sr_next == '0);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      sa_q     <= '0;
      sb_q     <= '0;
      sr_q     <= '0;
      carry_q  <= 1'b0;
      idx_q    <= '0;
      result_q <= '0;
      cout_q   <= 1'b0;
      ovf_q    <= 1'b0;
      zero_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      sa_q     <= sa_d;
      sb_q     <= sb_d;
      sr_q     <= sr_d;
      carry_q  <= carry_d;
      idx_q    <= idx_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      ovf_q    <= ovf_d;
      zero_q   <= zero_d;
    end
  end

  assign busy   = (state_q == S_RUN);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign ovf    = ovf_q;
  assign zero   = zero_q;

endmodule
